frame64_deser: RTL and testbench

//   Serial-to-parallel frame receiver, the write side of the 16x4 bit-addressed register bank.
//   - Accepts a 64-bit serial frame, one bit per qualified tick.
//   - Assembles each group of 4 bits into a nibble and writes it to bank[rg_a].
//   - Exposes a combinational read port so the scanning/readout side can fetch nibbles.

---
 rtl/frame64_deser_pkg.sv | 14 +
 rtl/bitaddr_ctr.sv | 40 ++++
 rtl/frame64_deser.sv | 120 ++++++++++++
 tb/tb_frame64_deser.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame64_deser_pkg.sv
// Shared definitions for the 64-bit serial frame receiver: default bank geometry and
// FSM state codes.
package frame64_deser_pkg;

  localparam int unsigned NREG_DEF = 16;
  localparam int unsigned NBIT_DEF = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRecv = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/bitaddr_ctr.sv
// Bit-addressed position counter {rg_a, bit_a}: increments on en, synchronous clear on sclr,
// asynchronous clear on clr. Wraps naturally at the top of the frame.
module bitaddr_ctr
  import frame64_deser_pkg::*;
#(
  parameter int unsigned RG_W  = $clog2(NREG_DEF),
  parameter int unsigned BIT_W = $clog2(NBIT_DEF)
) (
  input  logic             tick,
  input  logic             clr,
  input  logic             en,
  input  logic             sclr,
  output logic [RG_W-1:0]  rg_a,
  output logic [BIT_W-1:0] bit_a
);

  localparam int unsigned W = RG_W + BIT_W;

  logic [W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (sclr) begin
      pos_d = '0;
    end else if (en) begin
      pos_d = pos_q + W'(1);
    end
  end

  always_ff @(posedge tick or posedge clr) begin
    if (clr) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign {rg_a, bit_a} = pos_q;

endmodule

// File: rtl/frame64_deser.sv
// Serial-to-parallel frame receiver: assembles NREG*NBIT serial bits into nibbles and writes
// them into a register bank with a combinational read port.
module frame64_deser
  import frame64_deser_pkg::*;
#(
  parameter int unsigned NREG      = NREG_DEF,
  parameter int unsigned NBIT      = NBIT_DEF,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned RG_W     = $clog2(NREG),
  localparam int unsigned BIT_W    = $clog2(NBIT)
) (
  input  logic            tick,
  input  logic            clr,
  input  logic            start,
  input  logic            abort,
  input  logic            sin,
  input  logic            sin_valid,
  input  logic [RG_W-1:0] rd_addr,
  output logic [NBIT-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic            nib_wr,
  output logic [RG_W-1:0] nib_idx
);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBIT - 1);
  localparam logic [RG_W-1:0]  RG_LAST  = RG_W'(NREG - 1);

  state_e state_q, state_d;

  logic [RG_W-1:0]  rg_a;
  logic [BIT_W-1:0] bit_a;
  logic [BIT_W-1:0] bit_pos;
  logic             accept, ctr_sclr, nib_last, frame_last, nib_wr_d;
  logic [NBIT-1:0]  shift_q, shift_d, nib_new;
  logic [NBIT-1:0]  bank_q [NREG];
  logic             nib_wr_q;
  logic [RG_W-1:0]  nib_idx_q;

  assign accept     = (state_q == StRecv) && sin_valid && !abort;
  assign ctr_sclr   = (state_q == StIdle) && start && !abort;
  assign nib_last   = (bit_a == BIT_LAST);
  assign frame_last = nib_last && (rg_a == RG_LAST);
  assign bit_pos    = LSB_FIRST ? bit_a : BIT_LAST - bit_a;
  assign nib_wr_d   = accept && nib_last;

  bitaddr_ctr #(
    .RG_W  (RG_W),
    .BIT_W (BIT_W)
  ) u_ctr (
    .tick  (tick),
    .clr   (clr),
    .en    (accept),
    .sclr  (ctr_sclr),
    .rg_a  (rg_a),
    .bit_a (bit_a)
  );

  // Completed nibble includes the bit arriving on this edge.
  always_comb begin
    nib_new          = shift_q;
    nib_new[bit_pos] = sin;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StRecv;
          shift_d = '0;
        end
      end
      StRecv: begin
        if (abort) begin
          state_d = StIdle;
        end else if (sin_valid) begin
          shift_d = nib_last ? '0 : nib_new;
          if (frame_last) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tick or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      nib_wr_q  <= 1'b0;
      nib_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      nib_wr_q <= nib_wr_d;
      if (nib_wr_d) begin
        nib_idx_q <= rg_a;
      end
    end
  end

  always_ff @(posedge tick or posedge clr) begin
    if (clr) begin
      bank_q <= '{default: '0};
    end else if (nib_wr_d) begin
      bank_q[rg_a] <= nib_new;
    end
  end

  assign rd_data = bank_q[rd_addr];
  assign busy    = (state_q == StRecv);
  assign done    = (state_q == StDone);
  assign nib_wr  = nib_wr_q;
  assign nib_idx = nib_idx_q;

endmodule

// File: tb/tb_frame64_deser.sv
// Scoreboard bench for frame64_deser: LSB-first and MSB-first instances share one serial
// stream; expected nibble writes are queued by the stimulus and popped by a monitor.
module tb_frame64_deser;

  logic       tick = 1'b0;
  logic       clr, start, abort, sin, sin_valid;
  logic       rd_mode;
  logic [3:0] rd_man, rd_addr;
  logic [3:0] rd_data_l, rd_data_m, nib_idx_l, nib_idx_m;
  logic       busy_l, busy_m, done_l, done_m, nib_wr_l, nib_wr_m;

  // While streaming, read back whatever was just written so the monitor sees the data.
  assign rd_addr = rd_mode ? rd_man : nib_idx_l;

  always #5 tick = ~tick;

  frame64_deser #(.NREG(16), .NBIT(4), .LSB_FIRST(1'b1)) dut_l (
    .tick(tick), .clr(clr), .start(start), .abort(abort), .sin(sin), .sin_valid(sin_valid),
    .rd_addr(rd_addr), .rd_data(rd_data_l), .busy(busy_l), .done(done_l), .nib_wr(nib_wr_l),
    .nib_idx(nib_idx_l)
  );

  frame64_deser #(.NREG(16), .NBIT(4), .LSB_FIRST(1'b0)) dut_m (
    .tick(tick), .clr(clr), .start(start), .abort(abort), .sin(sin), .sin_valid(sin_valid),
    .rd_addr(rd_addr), .rd_data(rd_data_m), .busy(busy_m), .done(done_m), .nib_wr(nib_wr_m),
    .nib_idx(nib_idx_m)
  );

  int         n_pass = 0;
  int         n_chk = 0;
  int         done_cnt = 0;
  int         exp_done = 0;
  bit         done_prev = 1'b0;
  int         exp_idx_q[$];
  logic [3:0] exp_l_q[$];
  logic [3:0] exp_m_q[$];
  logic [3:0] ref_l[16];
  logic [3:0] ref_m[16];
  int         cur_l, cur_m;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference model: bit i of a frame belongs to nibble i/4 at offset i%4 (LSB first)
  // or 3-i%4 (MSB first).
  task automatic model_bit(input int i, input logic b);
    if (b) begin
      cur_l |= 1 << (i % 4);
      cur_m |= 1 << (3 - i % 4);
    end
    if (i % 4 == 3) begin
      exp_idx_q.push_back(i / 4);
      exp_l_q.push_back(4'(cur_l));
      exp_m_q.push_back(4'(cur_m));
      ref_l[i / 4] = 4'(cur_l);
      ref_m[i / 4] = 4'(cur_m);
      cur_l = 0;
      cur_m = 0;
    end
    if (i == 63) exp_done++;
  endtask

  task automatic drive(input logic s, input logic b, input logic v, input logic a);
    @(posedge tick);
    #1;
    start     = s;
    sin       = b;
    sin_valid = v;
    abort     = a;
  endtask

  task automatic frame(input logic [63:0] bits, input bit gaps, input int abort_at,
                       input bit hold_start);
    drive(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    cur_l = 0;
    cur_m = 0;
    for (int i = 0; i < 64; i++) begin
      if (gaps && i > 0) drive(hold_start, 1'($urandom), 1'b0, 1'b0);
      if (i == abort_at) begin
        drive(hold_start, bits[i], 1'b1, 1'b1);
        break;
      end
      drive(hold_start, bits[i], 1'b1, 1'b0);
      model_bit(i, bits[i]);
    end
    drive(hold_start, 1'($urandom), 1'($urandom), 1'b0);
    @(negedge tick);
    if (abort_at >= 0) begin
      check("abort_busy", int'(busy_l), 0);
      check("abort_no_done", int'(done_l), 0);
    end else begin
      check("done_l", int'(done_l), 1);
      check("done_m", int'(done_m), 1);
      check("done_busy", int'(busy_l), 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge tick);
    check("idle_busy", int'(busy_l), 0);
    check("idle_done", int'(done_l), 0);
  endtask

  task automatic readback(input string tag);
    rd_mode = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_man = 4'(a);
      #1;
      check($sformatf("%s_l[%0d]", tag, a), int'(rd_data_l), int'(ref_l[a]));
      check($sformatf("%s_m[%0d]", tag, a), int'(rd_data_m), int'(ref_m[a]));
    end
    rd_mode = 1'b0;
  endtask

  always @(negedge tick) begin
    if (!clr) begin
      if (nib_wr_l || nib_wr_m) begin
        if (exp_idx_q.size() == 0) begin
          check("nib_wr_unexpected", 1, 0);
        end else begin
          int         ei;
          logic [3:0] el, em;
          ei = exp_idx_q.pop_front();
          el = exp_l_q.pop_front();
          em = exp_m_q.pop_front();
          check("nib_wr_l", int'(nib_wr_l), 1);
          check("nib_wr_m", int'(nib_wr_m), 1);
          check("nib_idx_l", int'(nib_idx_l), ei);
          check("nib_idx_m", int'(nib_idx_m), ei);
          check("nib_data_l", int'(rd_data_l), int'(el));
          check("nib_data_m", int'(rd_data_m), int'(em));
        end
      end
      if (done_l) done_cnt++;
      if (done_l && done_prev) check("done_width", 2, 1);
      done_prev = done_l;
    end
  end

  initial begin
    logic [63:0] bits;
    clr = 1'b1; start = 1'b0; abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    rd_mode = 1'b0; rd_man = 4'd0;
    for (int a = 0; a < 16; a++) begin
      ref_l[a] = 4'd0;
      ref_m[a] = 4'd0;
    end

    repeat (2) @(negedge tick);
    check("rst_busy", int'(busy_l), 0);
    check("rst_done", int'(done_l), 0);
    check("rst_nib_wr", int'(nib_wr_l), 0);
    check("rst_nib_idx", int'(nib_idx_l), 0);
    readback("rst");
    clr = 1'b0;

    // Pattern nibble k = k, continuous valid.
    for (int k = 0; k < 16; k++) bits[4*k +: 4] = 4'(k);
    frame(bits, 1'b0, -1, 1'b0);
    readback("pat");
    rd_mode = 1'b1;
    rd_man  = 4'd1;
    #1;
    check("msb_first_n1", int'(rd_data_m), 8);
    rd_mode = 1'b0;

    // Random frame, then the pattern with sin_valid low every other cycle.
    frame({$urandom, $urandom}, 1'b0, -1, 1'b0);
    frame(bits, 1'b1, -1, 1'b0);
    readback("gap");

    // Abort at bit 10 keeps nibbles 0..1 of the new frame, rest from the previous one.
    frame({$urandom, $urandom}, 1'b0, -1, 1'b0);
    frame({$urandom, $urandom}, 1'b0, 10, 1'b0);
    readback("abort");
    frame({$urandom, $urandom}, 1'b0, -1, 1'b0);
    readback("restart");

    // start held high throughout: one frame, one done.
    frame({$urandom, $urandom}, 1'b0, -1, 1'b1);
    readback("hold");

    for (int n = 0; n < 3; n++) frame({$urandom, $urandom}, 1'($urandom), -1, 1'b0);
    readback("rand");

    // clr mid-frame.
    bits = {$urandom, $urandom};
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cur_l = 0;
    cur_m = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, bits[i], 1'b1, 1'b0);
      model_bit(i, bits[i]);
    end
    @(negedge tick);
    clr = 1'b1;
    sin_valid = 1'b0;
    exp_idx_q.delete();
    exp_l_q.delete();
    exp_m_q.delete();
    for (int a = 0; a < 16; a++) begin
      ref_l[a] = 4'd0;
      ref_m[a] = 4'd0;
    end
    #2;
    check("clr_busy", int'(busy_l), 0);
    check("clr_busy_m", int'(busy_m), 0);
    check("clr_done", int'(done_l), 0);
    check("clr_nib_wr", int'(nib_wr_l), 0);
    check("clr_nib_idx", int'(nib_idx_l), 0);
    readback("clr");
    @(negedge tick);
    clr = 1'b0;
    done_prev = 1'b0;

    frame({$urandom, $urandom}, 1'b0, -1, 1'b0);
    readback("post_clr");

    repeat (3) @(negedge tick);
    check("pending_writes", exp_idx_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
